led_shift_driver: RTL and testbench



---
 rtl/led_shift_driver.sv | 116 +++++++++++
 tb/tb_led_shift_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/led_shift_driver.sv
// Sends each new DATA_W-bit pattern MSB-first to a 74HC595-style chain
// (sclk/sdata/latch) and flags loaded patterns that are not one-hot.
module led_shift_driver #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  output logic              sclk,
  output logic              sdata,
  output logic              latch,
  output logic              busy,
  output logic              onehot_err
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next, sent_reg;
  logic              force_send;
  logic [BIT_W-1:0]  bit_cnt;
  logic [PH_W-1:0]   phase;
  logic              start, phase_done, last_bit;

  function automatic logic is_onehot(input logic [DATA_W-1:0] v);
    return (v != '0) && ((v & (v - DATA_W'(1))) == '0);
  endfunction

  assign shift_next = shift_reg << 1;
  assign phase_done = (phase == PH_LAST);
  assign last_bit   = (bit_cnt == BIT_LAST);

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (force_send || (data_in != sent_reg)) begin
          start      = 1'b1;
          state_next = SHIFT_LO;
        end
      end
      SHIFT_LO: if (phase_done) state_next = SHIFT_HI;
      SHIFT_HI: if (phase_done) state_next = last_bit ? LATCH : SHIFT_LO;
      LATCH:    if (phase_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Control and pin registers; every pin is registered so it changes only on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sent_reg   <= '0;
      force_send <= 1'b1;
      bit_cnt    <= '0;
      phase      <= '0;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      latch      <= 1'b0;
      busy       <= 1'b0;
      onehot_err <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE) || phase_done) phase <= '0;
      else                               phase <= phase + PH_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            sent_reg   <= data_in;
            force_send <= 1'b0;
            busy       <= 1'b1;
            sdata      <= data_in[DATA_W-1];
            bit_cnt    <= '0;
            if (!is_onehot(data_in)) onehot_err <= 1'b1;
          end
        end
        SHIFT_LO: if (phase_done) sclk <= 1'b1;
        SHIFT_HI: begin
          if (phase_done) begin
            sclk <= 1'b0;
            if (last_bit) begin
              sdata <= 1'b0;
              latch <= 1'b1;
            end else begin
              sdata   <= shift_next[DATA_W-1];
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        LATCH: begin
          if (phase_done) begin
            latch <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Shift data needs no reset: it is always loaded before it is used.
  always_ff @(posedge clk) begin
    if (start)
      shift_reg <= data_in;
    else if ((state == SHIFT_HI) && phase_done && !last_bit)
      shift_reg <= shift_next;
  end

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench for led_shift_driver: decodes the serial stream back into
// frames and checks frame content, timing, error flag and reset behaviour.
module tb_led_shift_driver;

  logic       clk = 1'b0;
  logic       rst_n, rst_n_b;
  logic [7:0] data, data_b;
  logic       sclk, sdata, latch, busy, onehot_err;
  logic       sclk_b, sdata_b, latch_b, busy_b, err_b;

  always #50 clk = ~clk;

  led_shift_driver #(.DATA_W(8), .CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data), .sclk(sclk), .sdata(sdata),
    .latch(latch), .busy(busy), .onehot_err(onehot_err)
  );

  led_shift_driver #(.DATA_W(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .data_in(data_b), .sclk(sclk_b), .sdata(sdata_b),
    .latch(latch_b), .busy(busy_b), .onehot_err(err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decoder for the CLK_DIV=4 instance
  logic [7:0] cap;
  int         nbits = 0, busy_rises = 0, latch_cnt = 0, sclk_in_latch = 0, run = 0;
  logic [7:0] frames[$];
  int         frame_bits[$];
  int         busy_len[$];
  time        t_sclk = 0;

  always @(posedge busy) begin
    nbits = 0;
    cap = '0;
    busy_rises++;
  end
  always @(posedge sclk) begin
    cap = {cap[6:0], sdata};
    nbits++;
    t_sclk = $time;
  end
  always @(posedge latch) begin
    frames.push_back(cap);
    frame_bits.push_back(nbits);
    latch_cnt++;
    chk("latch delay after last sclk rise", 32'($time - t_sclk), 32'd400);
  end
  always @(negedge clk) begin
    if (busy) run++;
    else if (run != 0) begin
      busy_len.push_back(run);
      run = 0;
    end
    if (latch && sclk) sclk_in_latch++;
  end

  // Decoder for the CLK_DIV=1 instance
  int         cyc = 0;
  logic [7:0] cap_b;
  logic [7:0] start_b[$];
  logic [7:0] got_b[$];
  int         rise_b[$];

  always @(posedge clk) cyc++;
  always @(posedge busy_b) begin
    start_b.push_back(data_b);
    rise_b.push_back(cyc);
    cap_b = '0;
  end
  always @(posedge sclk_b) cap_b = {cap_b[6:0], sdata_b};
  always @(posedge latch_b) got_b.push_back(cap_b);

  task automatic wait_busy(input string tag);
    int i;
    i = 0;
    while (!busy && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, " started"}, 32'(busy), 32'd1);
  endtask

  task automatic frame_wait(input string tag);
    int i;
    wait_busy(tag);
    i = 0;
    while (busy && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk({tag, " ended"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0;
    data = 8'h01; data_b = 8'h01;
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({sclk, sdata, latch, busy, onehot_err}), 32'd0);

    // First frame after reset release
    rst_n = 1'b1;
    @(negedge clk);
    chk("first edge busy/sdata", 32'({busy, sdata}), 32'b10);
    frame_wait("f1");
    chk("f1 data", 32'(frames[$]), 32'h01);
    chk("f1 bit count", 32'(frame_bits[$]), 32'd8);
    chk("f1 busy cycles", 32'(busy_len[$]), 32'd68);
    chk("f1 latch pulses", 32'(latch_cnt), 32'd1);
    repeat (100) @(negedge clk);
    chk("stable input no traffic", 32'(busy_rises), 32'd1);

    // Idle step 01 -> 02
    data = 8'h02;
    frame_wait("f2");
    chk("f2 data", 32'(frames[$]), 32'h02);
    chk("f2 latch pulses", 32'(latch_cnt), 32'd2);
    chk("f2 onehot_err", 32'(onehot_err), 32'd0);
    chk("f2 frame count", 32'(busy_rises), 32'd2);

    // Changes during a frame: 80 is dropped, 01 wins
    data = 8'h04;
    wait_busy("f3");
    repeat (10) @(negedge clk);
    data = 8'h80;
    repeat (10) @(negedge clk);
    data = 8'h01;
    frame_wait("f3");
    frame_wait("f4");
    chk("f3 data unaltered", 32'(frames[frames.size()-2]), 32'h04);
    chk("f4 newest data", 32'(frames[$]), 32'h01);
    repeat (100) @(negedge clk);
    chk("no frame for 80", 32'(busy_rises), 32'd4);
    chk("latch pulses f4", 32'(latch_cnt), 32'd4);

    // Non-one-hot pattern sets the sticky flag
    data = 8'h03;
    frame_wait("f5");
    chk("f5 data", 32'(frames[$]), 32'h03);
    chk("f5 onehot_err set", 32'(onehot_err), 32'd1);
    data = 8'h04;
    wait_busy("f6");
    repeat (20) @(negedge clk);
    chk("onehot_err sticky", 32'(onehot_err), 32'd1);

    // Reset in the middle of a frame
    #10 rst_n = 1'b0;
    #1 chk("async reset outputs", 32'({sclk, sdata, latch, busy, onehot_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frame_wait("f7");
    chk("f7 resend data", 32'(frames[$]), 32'h04);
    chk("f7 bit count", 32'(frame_bits[$]), 32'd8);
    chk("f7 busy cycles", 32'(busy_len[$]), 32'd68);
    chk("f7 latch pulses", 32'(latch_cnt), 32'd6);
    chk("onehot_err cleared", 32'(onehot_err), 32'd0);
    chk("sclk low during latch", 32'(sclk_in_latch), 32'd0);

    // CLK_DIV=1, input changing every cycle
    rst_n_b = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      data_b = (data_b == 8'h08) ? 8'h01 : (data_b << 1);
    end
    chk("div1 frames seen", 32'(got_b.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("div1 frame %0d data", i), 32'(got_b[i]), 32'(start_b[i]));
      if (i > 0) chk($sformatf("div1 period %0d", i), 32'(rise_b[i] - rise_b[i-1]), 32'd18);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
